// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame geometry, parity_mode bit positions, FSM states
// and the parity helper used by both transmitter and receiver.
package uart_tx_pkg;

   localparam int unsigned FRAME_BITS  = 11;
   localparam int unsigned DATA_BITS   = 8;
   localparam int unsigned BIT_IDX_W   = 3;
   localparam int unsigned PAR_EN_IDX  = 0;
   localparam int unsigned PAR_ODD_IDX = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_e;

   // Bit 9 of the frame: parity when enabled, otherwise a second stop bit.
   function automatic logic frame_bit9(input logic [DATA_BITS-1:0] data,
                                       input logic [1:0]           mode,
                                       input logic                 stop_level);
      if (mode[PAR_EN_IDX])
         return (^data) ^ mode[PAR_ODD_IDX];
      return stop_level;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high in the last cycle of each max(clk_div,1)-cycle period.
module uart_baud_tick #(
   parameter int unsigned CLK_DIV_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CLK_DIV_WIDTH-1:0] clk_div,
   input  logic                     restart,
   output logic                     tick
);

   logic [CLK_DIV_WIDTH-1:0] cnt_q;
   logic [CLK_DIV_WIDTH-1:0] last_c;

   // Terminal count never exceeds 2^W-2, so the counter cannot wrap.
   assign last_c = (clk_div <= CLK_DIV_WIDTH'(1)) ? '0 : clk_div - CLK_DIV_WIDTH'(1);
   assign tick   = (cnt_q >= last_c);

   always_ff @(posedge clk) begin
      if (reset || restart || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CLK_DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 11-bit frame (start, 8 data LSB first, parity/stop2, stop),
// one-cycle accept latency, done/overrun pulses, back-to-back capable.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int unsigned CLK_DIV_WIDTH = 8,
   parameter logic        START_BIT     = 1'b0,
   parameter logic        STOP_BIT      = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CLK_DIV_WIDTH-1:0] clk_div,
   input  logic [1:0]               parity_mode,
   input  logic                     we,
   input  logic [DATA_BITS-1:0]     datai,
   output logic                     tx,
   output logic                     busy,
   output logic                     done,
   output logic                     overrun
);

   localparam int unsigned SHIFT_W = FRAME_BITS - 1;

   tx_state_e                state_q;
   logic [SHIFT_W-1:0]       shift_q;
   logic [SHIFT_W-1:0]       shift_d;
   logic [BIT_IDX_W-1:0]     bit_idx_q;
   logic [CLK_DIV_WIDTH-1:0] div_q;
   logic                     tx_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     ovr_q;

   logic                     accept_c;
   logic                     tick_c;
   logic                     one_cycle_bit_c;
   logic [CLK_DIV_WIDTH-1:0] tick_div_c;

   assign accept_c        = we && (state_q == ST_IDLE);
   assign one_cycle_bit_c = (div_q <= CLK_DIV_WIDTH'(1));
   assign shift_d         = {STOP_BIT, frame_bit9(datai, parity_mode, STOP_BIT), datai};

   // The done cycle is the last stop-bit cycle, so the STOP state itself runs
   // one cycle short; with 1-cycle bits PAR goes straight to IDLE instead.
   assign tick_div_c = (state_q == ST_STOP) ? div_q - CLK_DIV_WIDTH'(1) : div_q;

   uart_baud_tick #(
      .CLK_DIV_WIDTH (CLK_DIV_WIDTH)
   ) u_baud (
      .clk     (clk),
      .reset   (reset),
      .clk_div (tick_div_c),
      .restart (accept_c),
      .tick    (tick_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         div_q     <= '0;
         tx_q      <= STOP_BIT;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         ovr_q  <= we && busy_q;

         case (state_q)
            ST_IDLE: begin
               tx_q   <= STOP_BIT;
               busy_q <= 1'b0;
               if (we) begin
                  state_q   <= ST_START;
                  tx_q      <= START_BIT;
                  busy_q    <= 1'b1;
                  shift_q   <= shift_d;
                  div_q     <= clk_div;
                  bit_idx_q <= '0;
               end
            end

            ST_START: begin
               if (tick_c) begin
                  tx_q    <= shift_q[0];
                  shift_q <= {STOP_BIT, shift_q[SHIFT_W-1:1]};
                  state_q <= ST_DATA;
               end
            end

            // bit_idx_q names the data bit currently on the line.
            ST_DATA: begin
               if (tick_c) begin
                  tx_q      <= shift_q[0];
                  shift_q   <= {STOP_BIT, shift_q[SHIFT_W-1:1]};
                  bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
                  if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                     state_q <= ST_PAR;
                  end
               end
            end

            ST_PAR: begin
               if (tick_c) begin
                  tx_q <= STOP_BIT;
                  if (one_cycle_bit_c) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_STOP;
                  end
               end
            end

            ST_STOP: begin
               if (tick_c) begin
                  state_q <= ST_IDLE;
                  tx_q    <= STOP_BIT;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               tx_q    <= STOP_BIT;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign overrun = ovr_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames checked cycle by cycle plus
// overrun, mid-frame reset and back-to-back sequences.
module tb_uart_tx;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] clk_div;
   logic [1:0]   parity_mode;
   logic         we;
   logic [7:0]   datai;
   logic         tx;
   logic         busy;
   logic         done;
   logic         overrun;

   int n_tests   = 0;
   int n_fail    = 0;
   int done_seen = 0;

   typedef struct {
      logic [7:0]   d;
      logic [1:0]   pm;
      logic [W-1:0] div;
      logic [10:0]  frame;   // bit 0 = start bit, bit 10 = final stop bit
   } vec_t;

   localparam int NVEC = 10;
   vec_t vecs[NVEC];

   always #5 clk = ~clk;

   uart_tx dut (
      .clk         (clk),
      .reset       (reset),
      .clk_div     (clk_div),
      .parity_mode (parity_mode),
      .we          (we),
      .datai       (datai),
      .tx          (tx),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a write for one cycle, then scramble the inputs to show they are ignored.
   task automatic launch(input vec_t v);
      we          = 1'b1;
      datai       = v.d;
      parity_mode = v.pm;
      clk_div     = v.div;
      step();
      we          = 1'b0;
      datai       = 8'h00;
      parity_mode = 2'b00;
      clk_div     = W'(7);
   endtask

   // Entered in cycle 1 of a frame; leaves in the cycle after the done cycle.
   task automatic run_frame(input vec_t v, input int ovr_at, input bit chain, input vec_t nv);
      int          n;
      int          bi;
      int          last;
      logic [10:0] obs;
      logic        perr;
      n    = (v.div <= W'(1)) ? 1 : int'(v.div);
      last = 11 * n;
      obs  = '0;
      for (int c = 1; c <= last; c++) begin
         bi = (c - 1) / n;
         chk("tx", 32'(tx), 32'(v.frame[bi]));
         chk("busy", 32'(busy), 32'(c != last));
         chk("done", 32'(done), 32'(c == last));
         chk("overrun", 32'(overrun), 32'((ovr_at > 0) && (c == ovr_at + 1)));
         if (done) done_seen++;
         if ((c - 1) % n == n / 2) obs[bi] = tx;
         we = 1'b0;
         if (c == ovr_at) begin
            we          = 1'b1;
            datai       = 8'hFF;
            parity_mode = 2'b11;
            clk_div     = W'(1);
         end else if (chain && (c == last)) begin
            we          = 1'b1;
            datai       = nv.d;
            parity_mode = nv.pm;
            clk_div     = nv.div;
         end
         step();
      end
      we = 1'b0;
      // Receiver-side view of the sampled frame.
      perr = v.pm[0] ? (obs[9] != ((^obs[8:1]) ^ v.pm[1])) : (obs[9] != 1'b1);
      chk("rx_data", 32'(obs[8:1]), 32'(v.d));
      chk("rx_error", 32'(perr), 32'h0);
      chk("rx_framing", 32'({obs[10], obs[0]}), 32'h2);
   endtask

   vec_t v_ovr;
   vec_t b2b[3];
   vec_t v_rst;
   vec_t v_5a;

   initial begin
      vecs[0] = '{8'hA5, 2'b00, W'(8),   11'h74A};
      vecs[1] = '{8'h03, 2'b01, W'(4),   11'h406};
      vecs[2] = '{8'h03, 2'b11, W'(4),   11'h606};
      vecs[3] = '{8'h03, 2'b00, W'(4),   11'h606};
      vecs[4] = '{8'h5A, 2'b01, W'(2),   11'h4B4};
      vecs[5] = '{8'h01, 2'b11, W'(1),   11'h402};
      vecs[6] = '{8'h80, 2'b01, W'(3),   11'h700};
      vecs[7] = '{8'hFF, 2'b10, W'(0),   11'h7FE};
      vecs[8] = '{8'h00, 2'b11, W'(5),   11'h600};
      vecs[9] = '{8'hC3, 2'b00, W'(255), 11'h786};
      v_ovr   = '{8'h3C, 2'b00, W'(4),   11'h678};
      b2b[0]  = '{8'h11, 2'b00, W'(0),   11'h622};
      b2b[1]  = '{8'h22, 2'b00, W'(0),   11'h644};
      b2b[2]  = '{8'h33, 2'b00, W'(0),   11'h666};
      v_rst   = '{8'h96, 2'b00, W'(3),   11'h72C};
      v_5a    = '{8'h5A, 2'b00, W'(2),   11'h6B4};

      // Reset with a write held high: the write must be ignored.
      reset       = 1'b1;
      we          = 1'b1;
      datai       = 8'hA5;
      parity_mode = 2'b00;
      clk_div     = W'(4);
      repeat (3) step();
      chk("reset_tx", 32'(tx), 32'h1);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_overrun", 32'(overrun), 32'h0);
      reset = 1'b0;
      we    = 1'b0;
      step();
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_tx", 32'(tx), 32'h1);
      step();

      for (int i = 0; i < NVEC; i++) begin
         launch(vecs[i]);
         run_frame(vecs[i], 0, 1'b0, vecs[i]);
         chk("gap_tx", 32'(tx), 32'h1);
         step();
      end

      // Write arriving at cycle 10 of a frame.
      launch(v_ovr);
      run_frame(v_ovr, 10, 1'b0, v_ovr);
      step();

      // Three back-to-back frames with 1-cycle bits.
      done_seen = 0;
      launch(b2b[0]);
      run_frame(b2b[0], 0, 1'b1, b2b[1]);
      run_frame(b2b[1], 0, 1'b1, b2b[2]);
      run_frame(b2b[2], 0, 1'b0, b2b[2]);
      chk("b2b_done_count", 32'(done_seen), 32'd3);
      step();

      // Reset while data bit 3 is on the line.
      launch(v_rst);
      repeat (12) step();
      chk("pre_reset_tx", 32'(tx), 32'h0);
      chk("pre_reset_busy", 32'(busy), 32'h1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_tx", 32'(tx), 32'h1);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_done", 32'(done), 32'h0);
      for (int k = 0; k < 8; k++) begin
         step();
         chk("postrst_done", 32'(done), 32'h0);
         chk("postrst_tx", 32'(tx), 32'h1);
      end
      launch(v_5a);
      run_frame(v_5a, 0, 1'b0, v_5a);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV_WIDTH, default 8, width of clk_div.
REQ-002 SHALL have parameter START_BIT, default 0, line level of start bit.
REQ-003 SHALL have parameter STOP_BIT, default 1, line level of stop bits and idle line.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port clk_div  input  CLK_DIV_WIDTH  clk cycles per bit.
REQ-007 SHALL have port parity_mode  input  2  [0]=parity enable, [1]=odd (1) / even (0).
REQ-008 SHALL have port we  input  1  write strobe; datai valid when high.
REQ-009 SHALL have port datai  input  8  byte to transmit.
REQ-010 SHALL have port tx  output  1  serial line.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when we arrives while busy.

Function
REQ-014 SHALL use a fixed 11-bit frame: START_BIT, datai[0]..datai[7] (LSB first), bit 9, STOP_BIT.
REQ-015 SHALL set bit 9 to the XOR of the 8 data bits when parity_mode[0]=1 and parity_mode[1]=0, and to its inverse when parity_mode[1]=1.
REQ-016 SHALL set bit 9 to STOP_BIT when parity_mode[0]=0, giving two stop bits.
REQ-017 SHALL accept we only while busy=0; datai, clk_div and parity_mode are captured in that cycle and ignored for the rest of the frame.
REQ-018 SHALL drive the start bit on tx in the cycle after the accepting we (latency 1), with busy=1 in that same cycle.
REQ-019 SHALL hold each bit for max(clk_div,1) cycles; clk_div of 0 or 1 gives 1 cycle per bit.
REQ-020 SHALL implement states IDLE -> START -> DATA (8 bits) -> PAR (bit 9) -> STOP -> IDLE, advancing on a bit-period tick.
REQ-021 SHALL count bit-period cycles with a CLK_DIV_WIDTH counter cleared at frame start and on each tick, with no wrap-around error at clk_div = 2^CLK_DIV_WIDTH-1.
REQ-022 SHALL, at the end of the STOP period, pulse done for 1 cycle, drop busy, and return tx to STOP_BIT in the same cycle.
REQ-023 SHALL accept a we asserted in the done cycle (busy=0), starting back-to-back frames with no idle bit.
REQ-024 SHALL pulse overrun for 1 cycle on any we while busy=1 and leave the current frame unaffected.
REQ-025 SHALL hold tx=STOP_BIT continuously in IDLE.

Reset
REQ-026 SHALL, in the cycle after reset=1, set tx=STOP_BIT, busy=0, done=0, overrun=0, state IDLE, counters 0, including mid-frame, with no done pulse.
REQ-027 SHALL ignore we in any cycle where reset=1.

Structure
REQ-028 SHALL take FRAME_BITS=11 and the parity_mode bit positions from a shared uart_defs include that both transmitter and receiver use.
REQ-029 SHALL implement the bit-period counter/tick as sub-module uart_baud_tick (inputs clk, reset, clk_div, restart; output tick), reusable by the receiver.

Verification
REQ-030 SHALL check loopback into the receiver with clk_div=8, parity off, datai=0xA5 -> receiver re=1, datao=0xA5, error=0.
REQ-031 SHALL check clk_div=4 with we at cycle 0 -> tx=START_BIT cycles 1-4, data bit0 at cycles 5-8, done at cycle 44, busy low from cycle 44.
REQ-032 SHALL check datai=0x03 -> bit 9=0 with even parity enabled, bit 9=1 with odd parity, bit 9=STOP_BIT with parity off; each loopback gives error=0.
REQ-033 SHALL check we at cycle 10 of a frame with datai=0xFF -> overrun=1 for 1 cycle, and the frame completes with the original byte.
REQ-034 SHALL check reset during data bit 3 -> next cycle tx=1, busy=0, and no done pulse; a subsequent we=0x5A transmits correctly.
REQ-035 SHALL check clk_div=0 with back-to-back we in each done cycle for 3 bytes -> 33 contiguous bit-cycles and 3 done pulses.
